// File: rtl/min_sad_select_pkg.sv
// Shared widths, sentinel SAD value and FSM state encoding for the min-SAD
// candidate selector.
package min_sad_select_pkg;

    localparam int SAD_W = 12;
    localparam int IDX_W = 4;
    localparam logic [SAD_W-1:0] MAX_SAD = 12'hFFF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/min_sad_select_if.sv
// Candidate stream in, best-match result out. The SAD producer side is the
// master; the selector is the slave.
interface min_sad_select_if;
    import min_sad_select_pkg::*;

    logic             start;
    logic             sad_valid;
    logic [SAD_W-1:0] sad;
    logic             busy;
    logic             done;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_x;
    logic [IDX_W-1:0] best_y;

    modport master (
        output start, sad_valid, sad,
        input  busy, done, best_sad, best_x, best_y
    );

    modport slave (
        input  start, sad_valid, sad,
        output busy, done, best_sad, best_x, best_y
    );

endinterface

// File: rtl/min_sad_select.sv
// Walks a SEARCH_W x SEARCH_H candidate window in raster order and keeps the
// first candidate with the strictly smallest SAD.
module min_sad_select #(
    parameter int SEARCH_W = 13,
    parameter int SEARCH_H = 13
) (
    input logic             clk,
    input logic             rst_n,
    min_sad_select_if.slave bus
);
    import min_sad_select_pkg::*;

    localparam logic [IDX_W-1:0] LAST_X = IDX_W'(SEARCH_W - 1);
    localparam logic [IDX_W-1:0] LAST_Y = IDX_W'(SEARCH_H - 1);

    logic [1:0]       state_q, state_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_x_q, best_x_d;
    logic [IDX_W-1:0] best_y_q, best_y_d;
    logic [IDX_W-1:0] cx_q, cx_d;
    logic [IDX_W-1:0] cy_q, cy_d;

    always_comb begin
        state_d    = state_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        cx_d       = cx_q;
        cy_d       = cy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_SEARCH;
                    best_sad_d = MAX_SAD;
                    best_x_d   = '0;
                    best_y_d   = '0;
                    cx_d       = '0;
                    cy_d       = '0;
                end
            end
            ST_SEARCH: begin
                if (bus.sad_valid) begin
                    // Strict less-than keeps the earliest raster position on ties.
                    if (bus.sad < best_sad_q) begin
                        best_sad_d = bus.sad;
                        best_x_d   = cx_q;
                        best_y_d   = cy_q;
                    end
                    if (cx_q == LAST_X) begin
                        if (cy_q == LAST_Y) begin
                            state_d = ST_DONE;
                        end else begin
                            cx_d = '0;
                            cy_d = cy_q + 1'b1;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            best_sad_q <= MAX_SAD;
            best_x_q   <= '0;
            best_y_q   <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
        end else begin
            state_q    <= state_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
        end
    end

    assign bus.busy     = (state_q == ST_SEARCH);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.best_sad = best_sad_q;
    assign bus.best_x   = best_x_q;
    assign bus.best_y   = best_y_q;

endmodule

// File: tb/tb_min_sad_select.sv
// Directed scenarios for min_sad_select: the default 13x13 window on one
// instance and a 2x2 window on a second instance sharing the clock and reset.
module tb_min_sad_select;
    import min_sad_select_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    min_sad_select_if bus ();
    min_sad_select_if bus2 ();

    min_sad_select #(.SEARCH_W(13), .SEARCH_H(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    min_sad_select #(.SEARCH_W(2), .SEARCH_H(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    // Presents one cycle of inputs to the 13x13 instance, then lands 1 time unit past the edge.
    task automatic step(input logic st, input logic v, input logic [11:0] s);
        bus.start     = st;
        bus.sad_valid = v;
        bus.sad       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.sad_valid  = 1'b0;
        bus.sad        = '0;
        bus2.start     = 1'b0;
        bus2.sad_valid = 1'b0;
        bus2.sad       = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.best_sad !== 12'hFFF) begin failures++; $display("FAIL reset_best_sad got=%h exp=fff", bus.best_sad); end
        checks++; if (bus.best_x !== 4'd0 || bus.best_y !== 4'd0) begin failures++; $display("FAIL reset_best_xy got=%0d,%0d exp=0,0", bus.best_x, bus.best_y); end
        checks++; if (bus2.busy !== 1'b0 || bus2.best_sad !== 12'hFFF) begin failures++; $display("FAIL reset_small got busy=%b sad=%h exp busy=0 sad=fff", bus2.busy, bus2.best_sad); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_min();
        step(1'b1, 1'b0, 12'd0);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_after_reset busy got=%b exp=1", bus.busy); end
        for (int i = 0; i < 169; i++) step(1'b0, 1'b1, (i == 84) ? 12'd37 : 12'd500);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_done got done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy); end
        checks++; if (bus.best_sad !== 12'd37) begin failures++; $display("FAIL single_best_sad got=%0d exp=37", bus.best_sad); end
        checks++; if (bus.best_x !== 4'd6 || bus.best_y !== 4'd6) begin failures++; $display("FAIL single_best_xy got=%0d,%0d exp=6,6", bus.best_x, bus.best_y); end
        step(1'b0, 1'b0, 12'd0);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_done_pulse got done=%b busy=%b exp 0,0", bus.done, bus.busy); end
        checks++; if (bus.best_sad !== 12'd37 || bus.best_x !== 4'd6 || bus.best_y !== 4'd6) begin failures++; $display("FAIL single_hold got=%0d/%0d,%0d exp=37/6,6", bus.best_sad, bus.best_x, bus.best_y); end
    endtask

    task automatic test_ties();
        step(1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 169; i++) step(1'b0, 1'b1, (i == 5 || i == 100) ? 12'd10 : 12'd200);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL ties_done got=%b exp=1", bus.done); end
        checks++; if (bus.best_sad !== 12'd10 || bus.best_x !== 4'd5 || bus.best_y !== 4'd0) begin failures++; $display("FAIL ties_best got=%0d/%0d,%0d exp=10/5,0", bus.best_sad, bus.best_x, bus.best_y); end
        step(1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_stalls();
        int busyCycles = 0;
        step(1'b1, 1'b0, 12'd0);
        // Stalled cycles carry sad=0 so a leaked stall would win the search.
        for (int i = 0; i < 338; i++) begin
            if (bus.busy === 1'b1) busyCycles++;
            if (i % 2 == 1) step(1'b0, 1'b1, (i == 337) ? 12'd3 : 12'd500);
            else            step(1'b0, 1'b0, 12'd0);
        end
        checks++; if (busyCycles != 338) begin failures++; $display("FAIL stalls_search_cycles got=%0d exp=338", busyCycles); end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL stalls_done got=%b exp=1", bus.done); end
        checks++; if (bus.best_sad !== 12'd3 || bus.best_x !== 4'd12 || bus.best_y !== 4'd12) begin failures++; $display("FAIL stalls_best got=%0d/%0d,%0d exp=3/12,12", bus.best_sad, bus.best_x, bus.best_y); end
        step(1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_reset_mid_search();
        logic sawDone = 1'b0;
        step(1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 12'(100 - i));
        checks++; if (bus.best_sad !== 12'd51 || bus.best_x !== 4'd10 || bus.best_y !== 4'd3) begin failures++; $display("FAIL midrst_pre got=%0d/%0d,%0d exp=51/10,3", bus.best_sad, bus.best_x, bus.best_y); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL midrst_async got busy=%b done=%b exp 0,0", bus.busy, bus.done); end
        checks++; if (bus.best_sad !== 12'hFFF || bus.best_x !== 4'd0 || bus.best_y !== 4'd0) begin failures++; $display("FAIL midrst_best got=%h/%0d,%0d exp=fff/0,0", bus.best_sad, bus.best_x, bus.best_y); end
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) sawDone = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 12'd0);
            if (bus.done === 1'b1) sawDone = 1'b1;
        end
        checks++; if (sawDone !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", sawDone); end
        checks++; if (bus.busy !== 1'b0 || bus.best_sad !== 12'hFFF) begin failures++; $display("FAIL midrst_needs_start got busy=%b sad=%h exp 0/fff", bus.busy, bus.best_sad); end
        step(1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 169; i++) step(1'b0, 1'b1, (i == 20) ? 12'd1 : 12'd300);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL midrst_fresh_done got=%b exp=1", bus.done); end
        checks++; if (bus.best_sad !== 12'd1 || bus.best_x !== 4'd7 || bus.best_y !== 4'd1) begin failures++; $display("FAIL midrst_fresh_best got=%0d/%0d,%0d exp=1/7,1", bus.best_sad, bus.best_x, bus.best_y); end
        step(1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_ignored_inputs();
        logic earlyDone = 1'b0;
        step(1'b0, 1'b1, 12'd0);
        step(1'b0, 1'b1, 12'd0);
        checks++; if (bus.busy !== 1'b0 || bus.best_sad !== 12'd1 || bus.best_x !== 4'd7 || bus.best_y !== 4'd1) begin failures++; $display("FAIL ign_idle_valid got busy=%b best=%0d/%0d,%0d exp 0/1/7,1", bus.busy, bus.best_sad, bus.best_x, bus.best_y); end
        step(1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 169; i++) begin
            if (i == 60) step(1'b1, 1'b0, 12'd0);
            step((i % 10 == 3), 1'b1, (i == 168) ? 12'd50 : 12'd400);
            if (i < 168 && bus.done === 1'b1) earlyDone = 1'b1;
        end
        checks++; if (earlyDone !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL ign_count got early=%b done=%b exp 0,1", earlyDone, bus.done); end
        checks++; if (bus.best_sad !== 12'd50 || bus.best_x !== 4'd12 || bus.best_y !== 4'd12) begin failures++; $display("FAIL ign_best got=%0d/%0d,%0d exp=50/12,12", bus.best_sad, bus.best_x, bus.best_y); end
        step(1'b1, 1'b1, 12'd0);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL ign_done_inputs got busy=%b done=%b exp 0,0", bus.busy, bus.done); end
        checks++; if (bus.best_sad !== 12'd50 || bus.best_x !== 4'd12 || bus.best_y !== 4'd12) begin failures++; $display("FAIL ign_hold got=%0d/%0d,%0d exp=50/12,12", bus.best_sad, bus.best_x, bus.best_y); end
        step(1'b0, 1'b0, 12'd0);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ign_done_start got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_small_array();
        logic [11:0] vals [4] = '{12'd9, 12'd4, 12'd4, 12'd7};
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        checks++; if (bus2.busy !== 1'b1) begin failures++; $display("FAIL small_busy got=%b exp=1", bus2.busy); end
        for (int i = 0; i < 4; i++) begin
            bus2.sad_valid = 1'b1;
            bus2.sad       = vals[i];
            @(posedge clk); #1;
            if (i == 2) begin
                checks++; if (bus2.done !== 1'b0) begin failures++; $display("FAIL small_early_done got=%b exp=0", bus2.done); end
            end
        end
        bus2.sad_valid = 1'b0;
        checks++; if (bus2.done !== 1'b1) begin failures++; $display("FAIL small_done got=%b exp=1", bus2.done); end
        checks++; if (bus2.best_sad !== 12'd4 || bus2.best_x !== 4'd1 || bus2.best_y !== 4'd0) begin failures++; $display("FAIL small_best got=%0d/%0d,%0d exp=4/1,0", bus2.best_sad, bus2.best_x, bus2.best_y); end
        @(posedge clk); #1;
        checks++; if (bus2.done !== 1'b0) begin failures++; $display("FAIL small_done_pulse got=%b exp=0", bus2.done); end
    endtask

    initial begin
        test_reset();
        test_single_min();
        test_ties();
        test_stalls();
        test_reset_mid_search();
        test_ignored_inputs();
        test_small_array();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
